collective_instr_gen: RTL and testbench

//  Per-node collective-instruction generator; successor to the fixed 8-rank reduce stage. Takes one host flit, looks up context/rank tables,

---
 rtl/collective_instr_gen.sv | 203 ++++++++++++++++++++
 tb/tb_collective_instr_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collective_instr_gen.sv
// collective_instr_gen: expands one host flit into 1..MaxFanout routed collective flits
// (uptree, broadcast, ring, recursive doubling). Optional INSTR_STATS_EN adds saturating counters.
module collective_instr_gen #(
   parameter int unsigned FlitWidth     = 73,
   parameter int unsigned LgNumProcs    = 3,
   parameter int unsigned CommTableSize = 4,
   parameter int unsigned MaxFanout     = 3,
   parameter int unsigned ChildrenWidth = 3,
   parameter int unsigned RootRank      = 0,
   parameter int unsigned AddrWidth     = (LgNumProcs > $clog2(CommTableSize)) ? LgNumProcs
                                                                                 : $clog2(CommTableSize),
   parameter int unsigned CfgWidth      = 9*MaxFanout+16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [FlitWidth-1:0]               packetIn,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [FlitWidth+ChildrenWidth-1:0] packetOut,
   input  logic                               cfg_we,
   input  logic                               cfg_sel,
   input  logic [AddrWidth-1:0]               cfg_addr,
   input  logic [CfgWidth-1:0]                cfg_wdata,
   output logic                               busy,
   output logic                               err_ctx
`ifdef INSTR_STATS_EN
  ,output logic [15:0]                        stat_in,
   output logic [15:0]                        stat_out,
   output logic [15:0]                        stat_drop
`endif
);

   localparam int unsigned NumProcs = 1 << LgNumProcs;
   localparam int unsigned CtxW     = (CommTableSize > 1) ? $clog2(CommTableSize) : 1;
   localparam int unsigned IdxW     = $clog2(MaxFanout+1);
   localparam int unsigned OutW     = FlitWidth + ChildrenWidth;
   localparam logic [LgNumProcs-1:0] RootIdx = LgNumProcs'(RootRank);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT} state_t;

   state_t                r_state;
   logic [FlitWidth-1:0]  r_flit;
   logic [IdxW-1:0]       r_idx;
   logic [IdxW-1:0]       r_count;
   logic [8:0]            r_rank [NumProcs];
   logic [CfgWidth-1:0]   r_comm [CommTableSize];

   logic [7:0]            w_ctx;
   logic                  w_ctx_ok;
   logic [CfgWidth-1:0]   w_entry;
   logic [8:0]            w_local;
   logic [2:0]            w_children;
   logic [3:0]            w_lg;
   logic [3:0]            w_tag;
   logic [1:0]            w_alg;
   logic [8:0]            w_slot0;
   logic [8:0]            w_ring_last;
   logic [8:0]            w_partner;
   logic [8:0]            w_nslot;
   logic [IdxW-1:0]       w_nidx;
   logic [IdxW-1:0]       w_count;
   logic                  w_drop;
   logic [8:0]            w_dst0;
   logic [ChildrenWidth-1:0] w_ch0;
   logic [ChildrenWidth-1:0] w_nch;

   assign in_ready = (r_state == S_IDLE) && !cfg_we;
   assign busy     = (r_state != S_IDLE);

   assign w_ctx       = r_flit[53:46];
   assign w_ctx_ok    = 32'(w_ctx) < CommTableSize;
   assign w_entry     = w_ctx_ok ? r_comm[w_ctx[CtxW-1:0]] : '0;
   assign w_local     = w_entry[CfgWidth-1 -: 9];
   assign w_children  = w_entry[CfgWidth-10 -: 3];
   assign w_lg        = w_entry[CfgWidth-13 -: 4];
   assign w_slot0     = w_entry[8:0];
   assign w_alg       = r_flit[37:36];
   assign w_tag       = r_flit[41:38];
   assign w_ring_last = (9'd1 << w_lg) - 9'd1;
   assign w_partner   = w_local ^ (9'd1 << w_tag);
   assign w_nidx      = r_idx + 1'b1;
   assign w_nch       = ChildrenWidth'(32'(r_count) - 32'(r_idx) - 32'd2);

   always_comb begin
      w_count = IdxW'(1);
      w_dst0  = r_rank[w_slot0[LgNumProcs-1:0]];
      w_ch0   = '0;
      w_drop  = !w_ctx_ok || (w_lg == 4'd0);
      case (w_alg)
         2'd0: begin
            if (32'(w_local) == RootRank) w_dst0 = r_rank[w_local[LgNumProcs-1:0]];
            w_ch0 = ChildrenWidth'(w_children);
         end
         2'd1: begin
            w_count = (32'(w_children) > MaxFanout) ? IdxW'(MaxFanout) : IdxW'(w_children);
            w_ch0   = ChildrenWidth'(w_count - 1'b1);
         end
         2'd2: begin
            if (w_local == w_ring_last) w_dst0 = r_rank[RootIdx];
         end
         default: begin
            w_dst0 = r_rank[w_partner[LgNumProcs-1:0]];
            if (w_tag >= w_lg) w_drop = 1'b1;
         end
      endcase
   end

   // Only broadcast emits more than one flit; its next destination comes from slot idx+1.
   always_comb begin
      w_nslot = w_slot0;
      for (int unsigned k = 0; k < MaxFanout; k++)
         if (32'(w_nidx) == k) w_nslot = w_entry[9*k +: 9];
   end

   function automatic logic [OutW-1:0] f_build(input logic [FlitWidth-1:0]     flit,
                                               input logic [8:0]               dst,
                                               input logic [ChildrenWidth-1:0] ch);
      logic [FlitWidth-1:0] f;
      f                  = flit;
      f[FlitWidth-1]     = 1'b1;
      f[FlitWidth-2 -: 9] = dst;
      return {ch, f};
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_flit    <= '0;
         r_idx     <= '0;
         r_count   <= '0;
         out_valid <= 1'b0;
         packetOut <= '0;
         err_ctx   <= 1'b0;
         for (int unsigned i = 0; i < NumProcs; i++)      r_rank[i] <= '0;
         for (int unsigned i = 0; i < CommTableSize; i++) r_comm[i] <= '0;
      end else begin
         err_ctx <= 1'b0;
         if (cfg_we && r_state == S_IDLE) begin
            if (!cfg_sel)
               r_rank[cfg_addr[LgNumProcs-1:0]] <= cfg_wdata[8:0];
            else if (32'(cfg_addr) < CommTableSize)
               r_comm[cfg_addr[CtxW-1:0]] <= cfg_wdata;
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid && !cfg_we) begin
                  r_flit  <= packetIn;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (w_drop) begin
                  err_ctx <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_count == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  packetOut <= f_build(r_flit, w_dst0, w_ch0);
                  out_valid <= 1'b1;
                  r_count   <= w_count;
                  r_idx     <= '0;
                  r_state   <= S_EMIT;
               end
            end
            default: begin
               if (out_ready) begin
                  if (r_idx == r_count - 1'b1) begin
                     out_valid <= 1'b0;
                     r_idx     <= '0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_idx     <= w_nidx;
                     packetOut <= f_build(r_flit, r_rank[w_nslot[LgNumProcs-1:0]], w_nch);
                  end
               end
            end
         endcase
      end
   end

`ifdef INSTR_STATS_EN
   logic [15:0] r_stat_in, r_stat_out, r_stat_drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_in   <= '0;
         r_stat_out  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (in_valid && in_ready && r_stat_in != '1)           r_stat_in   <= r_stat_in + 16'd1;
         if (out_valid && out_ready && r_stat_out != '1)        r_stat_out  <= r_stat_out + 16'd1;
         if (r_state == S_LOOKUP && w_drop && r_stat_drop != '1) r_stat_drop <= r_stat_drop + 16'd1;
      end
   end

   assign stat_in   = r_stat_in;
   assign stat_out  = r_stat_out;
   assign stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_collective_instr_gen.sv
// Directed bench for collective_instr_gen: inputs change and outputs are sampled on the falling edge.
module tb_collective_instr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [72:0] packetIn;
   logic        out_valid;
   logic        out_ready;
   logic [75:0] packetOut;
   logic        cfg_we;
   logic        cfg_sel;
   logic [2:0]  cfg_addr;
   logic [42:0] cfg_wdata;
   logic        busy;
   logic        err_ctx;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   collective_instr_gen #(
      .FlitWidth(73), .LgNumProcs(3), .CommTableSize(4),
      .MaxFanout(3), .ChildrenWidth(3), .RootRank(0)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .packetIn(packetIn),
      .out_valid(out_valid), .out_ready(out_ready), .packetOut(packetOut),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .busy(busy), .err_ctx(err_ctx)
   );

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [72:0] mkf(input logic [8:0] dst, input logic [7:0] ctx,
                                       input logic [7:0] tag, input logic [1:0] alg,
                                       input logic [31:0] pay);
      return {1'b1, dst, 9'o042, ctx, tag, alg, 4'h5, pay};
   endfunction

   function automatic logic [75:0] expo(input logic [72:0] f, input logic [8:0] dst,
                                        input logic [2:0] ch);
      return {ch, 1'b1, dst, f[62:0]};
   endfunction

   task automatic cfg_rank(input logic [2:0] a, input logic [8:0] coord);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = a; cfg_wdata = {34'd0, coord};
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg_comm(input logic [2:0] a, input logic [8:0] loc, input logic [2:0] ch,
                           input logic [3:0] lg, input logic [8:0] s0, input logic [8:0] s1,
                           input logic [8:0] s2);
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = a; cfg_wdata = {loc, ch, lg, s2, s1, s0};
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Returns on the falling edge of the LOOKUP cycle.
   task automatic send(input logic [72:0] f);
      in_valid = 1'b1; packetIn = f;
      #1 chk("in_ready_on_send", 80'(in_ready), 80'(1'b1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic watch(input int n, output int nv, output int ne);
      nv = 0; ne = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (out_valid) nv++;
         if (err_ctx)   ne++;
      end
   endtask

   initial begin
      logic [72:0] f;
      logic [75:0] hold;
      int nv, ne;

      rst = 1'b0; in_valid = 1'b0; packetIn = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_busy",      80'(busy),      80'(0));
      chk("rst_err",       80'(err_ctx),   80'(0));
      chk("rst_packetOut", 80'(packetOut), 80'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  80'(in_ready),  80'(1));

      for (int i = 0; i < 8; i++) cfg_rank(3'(i), 9'(64 + 9*i));

      // Uptree: slot0=1 -> rank[1]=9'o111, children field = 2
      cfg_comm(3'd0, 9'd3, 3'd2, 4'd3, 9'd1, 9'd0, 9'd0);
      f = mkf(9'o000, 8'd0, 8'h11, 2'd0, 32'hDEAD_0001);
      send(f);
      chk("up_lookup_valid", 80'(out_valid), 80'(0));
      chk("up_lookup_busy",  80'(busy),      80'(1));
      @(negedge clk);
      chk("up_valid", 80'(out_valid), 80'(1));
      chk("up_pkt",   80'(packetOut), 80'(expo(f, 9'o111, 3'd2)));
      @(negedge clk);
      chk("up_done_valid", 80'(out_valid), 80'(0));
      chk("up_done_busy",  80'(busy),      80'(0));

      // Uptree from root: own coordinates rank[0]
      cfg_comm(3'd1, 9'd0, 3'd1, 4'd3, 9'd4, 9'd0, 9'd0);
      f = mkf(9'o000, 8'd1, 8'h22, 2'd0, 32'h0000_0002);
      send(f);
      @(negedge clk);
      chk("root_pkt", 80'(packetOut), 80'(expo(f, 9'o100, 3'd1)));
      @(negedge clk);

      // Broadcast with backpressure on the second flit
      cfg_comm(3'd0, 9'd3, 3'd3, 4'd3, 9'd4, 9'd5, 9'd6);
      f = mkf(9'o000, 8'd0, 8'h33, 2'd1, 32'hCAFE_0003);
      send(f);
      @(negedge clk);
      chk("bc0_valid", 80'(out_valid), 80'(1));
      chk("bc0_pkt",   80'(packetOut), 80'(expo(f, 9'o144, 3'd2)));
      @(negedge clk);
      chk("bc1_pkt",   80'(packetOut), 80'(expo(f, 9'o155, 3'd1)));
      out_ready = 1'b0;
      @(negedge clk);
      chk("bc1_hold1", 80'(packetOut), 80'(expo(f, 9'o155, 3'd1)));
      chk("bc1_hold1_valid", 80'(out_valid), 80'(1));
      @(negedge clk);
      chk("bc1_hold2", 80'(packetOut), 80'(expo(f, 9'o155, 3'd1)));
      out_ready = 1'b1;
      @(negedge clk);
      chk("bc2_pkt",   80'(packetOut), 80'(expo(f, 9'o166, 3'd0)));
      @(negedge clk);
      chk("bc_done_valid", 80'(out_valid), 80'(0));
      chk("bc_done_busy",  80'(busy),      80'(0));

      // Broadcast leaf: nothing emitted, no error
      cfg_comm(3'd2, 9'd3, 3'd0, 4'd3, 9'd4, 9'd5, 9'd6);
      f = mkf(9'o000, 8'd2, 8'h44, 2'd1, 32'h0000_0004);
      send(f);
      chk("leaf_busy", 80'(busy), 80'(1));
      watch(4, nv, ne);
      chk("leaf_no_out", 80'(nv), 80'(0));
      chk("leaf_no_err", 80'(ne), 80'(0));
      chk("leaf_idle",   80'(busy), 80'(0));

      // Illegal context: one error pulse, no output
      f = mkf(9'o000, 8'd5, 8'h55, 2'd0, 32'h0000_0005);
      send(f);
      watch(4, nv, ne);
      chk("badctx_no_out", 80'(nv), 80'(0));
      chk("badctx_err",    80'(ne), 80'(1));

      // Ring: non-wrap then wrap to the root
      cfg_comm(3'd3, 9'd4, 3'd0, 4'd3, 9'd5, 9'd0, 9'd0);
      f = mkf(9'o000, 8'd3, 8'h66, 2'd2, 32'h0000_0006);
      send(f);
      @(negedge clk);
      chk("ring_pkt", 80'(packetOut), 80'(expo(f, 9'o155, 3'd0)));
      @(negedge clk);
      cfg_comm(3'd3, 9'd7, 3'd0, 4'd3, 9'd5, 9'd0, 9'd0);
      send(f);
      @(negedge clk);
      chk("ring_wrap_pkt", 80'(packetOut), 80'(expo(f, 9'o100, 3'd0)));
      @(negedge clk);

      // Recursive doubling: 5 ^ (1<<2) = 1; tag 3 with lg 3 is out of range
      cfg_comm(3'd3, 9'd5, 3'd0, 4'd3, 9'd0, 9'd0, 9'd0);
      f = mkf(9'o000, 8'd3, 8'h02, 2'd3, 32'h0000_0007);
      send(f);
      @(negedge clk);
      chk("dbl_pkt", 80'(packetOut), 80'(expo(f, 9'o111, 3'd0)));
      @(negedge clk);
      f = mkf(9'o000, 8'd3, 8'h03, 2'd3, 32'h0000_0008);
      send(f);
      watch(4, nv, ne);
      chk("dbl_drop_no_out", 80'(nv), 80'(0));
      chk("dbl_drop_err",    80'(ne), 80'(1));

      // Table write while busy is ignored
      out_ready = 1'b0;
      f = mkf(9'o000, 8'd0, 8'h77, 2'd1, 32'h0000_0009);
      send(f);
      @(negedge clk);
      hold = packetOut;
      chk("busycfg_pkt0", 80'(hold), 80'(expo(f, 9'o144, 3'd2)));
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd5; cfg_wdata = {34'd0, 9'o707};
      @(negedge clk);
      cfg_we = 1'b0;
      chk("busycfg_hold", 80'(packetOut), 80'(expo(f, 9'o144, 3'd2)));
      out_ready = 1'b1;
      @(negedge clk);
      chk("busycfg_pkt1", 80'(packetOut), 80'(expo(f, 9'o155, 3'd1)));
      repeat (2) @(negedge clk);
      chk("busycfg_idle", 80'(busy), 80'(0));

      // Table write in IDLE blocks in_ready for one cycle; flit is taken the next cycle
      cfg_comm(3'd2, 9'd3, 3'd1, 4'd3, 9'd7, 9'd0, 9'd0);
      f = mkf(9'o000, 8'd2, 8'h88, 2'd0, 32'h0000_000A);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd7; cfg_wdata = {34'd0, 9'o170};
      in_valid = 1'b1; packetIn = f;
      #1 chk("coll_in_ready_low", 80'(in_ready), 80'(0));
      @(negedge clk);
      cfg_we = 1'b0;
      chk("coll_busy_after_cfg", 80'(busy), 80'(0));
      #1 chk("coll_in_ready_high", 80'(in_ready), 80'(1));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("coll_pkt", 80'(packetOut), 80'(expo(f, 9'o170, 3'd1)));
      @(negedge clk);

      // Reset in the middle of an emit
      out_ready = 1'b0;
      f = mkf(9'o000, 8'd0, 8'h99, 2'd1, 32'h0000_000B);
      send(f);
      @(negedge clk);
      chk("mid_valid_before", 80'(out_valid), 80'(1));
      #2 rst = 1'b0;
      #1 chk("mid_valid_async", 80'(out_valid), 80'(0));
      chk("mid_busy_async",  80'(busy),      80'(0));
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 80'(in_ready), 80'(1));
      f = mkf(9'o000, 8'd0, 8'hAA, 2'd0, 32'h0000_000C);
      send(f);
      watch(4, nv, ne);
      chk("post_rst_no_out",   80'(nv), 80'(0));
      chk("post_rst_zero_tbl", 80'(ne), 80'(1));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
